// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: default parameter values
// and the encoding of the sys_reset state machine.
package button_conditioner_pkg;

  localparam int DEF_NUM_BUTTONS     = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_RESET_STRETCH   = 4;
  localparam int DEF_RESET_BUTTON    = 0;

  // sys_reset is high in HELD and STRETCH, low only in IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1,
    ST_STRETCH = 2'd2
  } rst_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board side (raw buttons) and the conditioner
// outputs feeding the AVR system.
interface button_conditioner_if
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS = DEF_NUM_BUTTONS
);

  logic [NUM_BUTTONS-1:0] buttons_raw;
  logic [NUM_BUTTONS-1:0] buttons;
  logic [NUM_BUTTONS-1:0] pressed;
  logic [NUM_BUTTONS-1:0] released;
  logic                   sys_reset;

  // master: drives the raw buttons and consumes conditioned results
  modport master (
    output buttons_raw,
    input  buttons,
    input  pressed,
    input  released,
    input  sys_reset
  );

  // slave: the conditioner itself
  modport slave (
    input  buttons_raw,
    output buttons,
    output pressed,
    output released,
    output sys_reset
  );

endinterface

// File: rtl/button_conditioner_debounce_bit.sv
// One button channel: two-flop synchronizer, mismatch counter that accepts a
// new level after DEBOUNCE_CYCLES consecutive differing samples, and
// registered one-cycle pressed/released pulses.
module debounce_bit
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic level_next,
  output logic pressed,
  output logic released
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          level_reg;
  logic          accept;
  logic          pressed_reg;
  logic          released_reg;

  // Bring the asynchronous board input into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive mismatches; any agreeing sample restarts the count
  always_comb begin
    cnt_next   = '0;
    level_next = level_reg;
    accept     = 1'b0;
    if (sync2_reg != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        accept     = 1'b1;
        level_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + CNT_ONE;
      end
    end
  end

  // Debounced level, counter and edge pulses aligned to the new level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      level_reg    <= 1'b0;
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      level_reg    <= level_next;
      pressed_reg  <= accept & sync2_reg;
      released_reg <= accept & ~sync2_reg;
    end
  end

  assign level    = level_reg;
  assign pressed  = pressed_reg;
  assign released = released_reg;

endmodule

// File: rtl/button_conditioner.sv
// Debounces every board button and derives a stretched system reset from
// the designated reset button. The reset FSM looks at the level each
// button is about to take, so sys_reset rises on the same edge as the
// debounced reset button and the stretch starts on the edge it falls.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RESET_STRETCH   = DEF_RESET_STRETCH,
  parameter int RESET_BUTTON    = DEF_RESET_BUTTON
) (
  input  logic                clk,
  input  logic                reset_n,
  button_conditioner_if.slave bus
);

  localparam int            SW           = $clog2(RESET_STRETCH);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(RESET_STRETCH - 1);
  localparam logic [SW-1:0] STRETCH_ONE  = SW'(1);

  logic [NUM_BUTTONS-1:0] level_w;
  logic [NUM_BUTTONS-1:0] level_next_w;
  logic [NUM_BUTTONS-1:0] pressed_w;
  logic [NUM_BUTTONS-1:0] released_w;

  rst_state_e    state_reg;
  rst_state_e    state_next;
  logic [SW-1:0] stretch_cnt_reg;
  logic [SW-1:0] stretch_cnt_next;
  logic          sys_reset_reg;
  logic          rst_btn;

  generate
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw       (bus.buttons_raw[gi]),
        .level     (level_w[gi]),
        .level_next(level_next_w[gi]),
        .pressed   (pressed_w[gi]),
        .released  (released_w[gi])
      );
    end
  endgenerate

  assign rst_btn = level_next_w[RESET_BUTTON];

  // Next state of the reset FSM and its stretch counter
  always_comb begin
    state_next       = state_reg;
    stretch_cnt_next = stretch_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rst_btn) state_next = ST_HELD;
      end
      ST_HELD: begin
        if (!rst_btn) begin
          state_next       = ST_STRETCH;
          stretch_cnt_next = '0;
        end
      end
      ST_STRETCH: begin
        if (rst_btn) begin
          state_next       = ST_HELD;
          stretch_cnt_next = '0;
        end else if (stretch_cnt_reg == STRETCH_LAST) begin
          state_next       = ST_IDLE;
          stretch_cnt_next = '0;
        end else begin
          stretch_cnt_next = stretch_cnt_reg + STRETCH_ONE;
        end
      end
      default: begin
        state_next       = ST_STRETCH;
        stretch_cnt_next = '0;
      end
    endcase
  end

  // FSM registers; coming out of reset behaves like a fresh stretch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_STRETCH;
      stretch_cnt_reg <= '0;
      sys_reset_reg   <= 1'b1;
    end else begin
      state_reg       <= state_next;
      stretch_cnt_reg <= stretch_cnt_next;
      sys_reset_reg   <= (state_next != ST_IDLE);
    end
  end

  assign bus.buttons   = level_w;
  assign bus.pressed   = pressed_w;
  assign bus.released  = released_w;
  assign bus.sys_reset = sys_reset_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a window-based reference model pushes the
// expected outputs for every clock edge into a queue, a monitor pops and
// compares them, and directed sequences measure latencies and stretch length.
module tb_button_conditioner;

  localparam int N  = 5;
  localparam int D  = 16;
  localparam int RS = 4;
  localparam int RB = 0;

  typedef struct packed {
    logic [N-1:0] buttons;
    logic [N-1:0] pressed;
    logic [N-1:0] released;
    logic         sys_reset;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks_total;
  int   checks_passed;
  exp_t exp_q[$];

  button_conditioner_if #(.NUM_BUTTONS(N)) bif ();

  button_conditioner #(
    .NUM_BUTTONS    (N),
    .DEBOUNCE_CYCLES(D),
    .RESET_STRETCH  (RS),
    .RESET_BUTTON   (RB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: a level is accepted when the last D synchronized samples
  // (raw seen two edges earlier) all disagree with it; sys_reset is high while
  // the reset button (or reset itself) was active within the last RS edges.
  initial begin
    logic [N-1:0] hist [0:D+1];
    logic [N-1:0] m_level;
    logic [N-1:0] newl;
    int           m_since;
    bit           all_diff;
    exp_t         e;
    m_level = '0;
    m_since = 1;
    for (int i = 0; i < D + 2; i++) hist[i] = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int i = 0; i < D + 2; i++) hist[i] = '0;
        m_level     = '0;
        m_since     = 1;
        e.buttons   = '0;
        e.pressed   = '0;
        e.released  = '0;
        e.sys_reset = 1'b1;
      end else begin
        for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bif.buttons_raw;
        newl = m_level;
        for (int b = 0; b < N; b++) begin
          all_diff = 1'b1;
          for (int k = 2; k <= D + 1; k++)
            if (hist[k][b] == m_level[b]) all_diff = 1'b0;
          if (all_diff) newl[b] = ~m_level[b];
        end
        e.buttons  = newl;
        e.pressed  = newl & ~m_level;
        e.released = ~newl & m_level;
        m_level    = newl;
        if (newl[RB]) m_since = 0;
        else          m_since++;
        e.sys_reset = (m_since <= RS);
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs with the queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("sb_buttons",   int'(bif.buttons),   int'(e.buttons));
        check("sb_pressed",   int'(bif.pressed),   int'(e.pressed));
        check("sb_released",  int'(bif.released),  int'(e.released));
        check("sb_sys_reset", int'(bif.sys_reset), int'(e.sys_reset));
        check("sb_exclusive", int'(bif.pressed & bif.released), 0);
        if ((bif.pressed | bif.released) != '0)
          $display("t=%0t event pressed=%b released=%b buttons=%b sys_reset=%b",
                   $time, bif.pressed, bif.released, bif.buttons, bif.sys_reset);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Stimulus and directed measurements
  initial begin
    int n;
    int bad;
    int pc;
    int rc;
    bit v;
    int hold [N];
    checks_total     = 0;
    checks_passed    = 0;
    reset_n          = 1'b0;
    bif.buttons_raw  = '0;

    // Power-on: three reset cycles, then count edges until sys_reset falls
    repeat (3) @(posedge clk);
    #1;
    check("por_sys_reset_in_reset", int'(bif.sys_reset), 1);
    check("por_buttons_in_reset", int'(bif.buttons), 0);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (bif.sys_reset && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("por_stretch_len", n, RS);
    wait_cycles(5);

    // Clean press on bit 2
    @(negedge clk);
    bif.buttons_raw[2] = 1'b1;
    n = 0;
    while (!bif.buttons[2] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("press_latency", n, D + 2);
    check("press_pulse", int'(bif.pressed[2]), 1);
    @(posedge clk);
    #1;
    check("press_pulse_one_cycle", int'(bif.pressed[2]), 0);
    @(negedge clk);
    bif.buttons_raw[2] = 1'b0;
    wait_cycles(25);

    // Bounce on bit 1: toggle every 3 cycles for 40 cycles, then hold 1
    v = 1'b0;
    bad = 0;
    pc = 0;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) v = ~v;
      bif.buttons_raw[1] = v;
      @(posedge clk);
      #1;
      if (bif.buttons[1]) bad++;
      if (bif.pressed[1]) pc++;
      @(negedge clk);
    end
    check("bounce_stays_low", bad, 0);
    bif.buttons_raw[1] = 1'b1;
    n = 0;
    while (!bif.buttons[1] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bif.pressed[1]) pc++;
    end
    check("bounce_latency", n, D + 2);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bif.pressed[1]) pc++;
    end
    check("bounce_single_pulse", pc, 1);
    @(negedge clk);
    bif.buttons_raw[1] = 1'b0;
    wait_cycles(25);

    // Reset button held for 30 cycles
    check("rstbtn_idle_before", int'(bif.sys_reset), 0);
    @(negedge clk);
    bif.buttons_raw[RB] = 1'b1;
    bad = 0;
    rc = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bif.buttons[RB]) begin
        rc++;
        if (!bif.sys_reset) bad++;
      end else if (bif.sys_reset) begin
        bad++;
      end
    end
    check("rstbtn_follows_button", bad, 0);
    check("rstbtn_high_cycles", rc, 30 - (D + 2) + 1);
    @(negedge clk);
    bif.buttons_raw[RB] = 1'b0;
    n = 0;
    while (bif.buttons[RB] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rstbtn_release_latency", n, D + 2);
    n = 0;
    while (bif.sys_reset && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rstbtn_stretch_len", n, RS);
    wait_cycles(5);

    // Mid-debounce reset on bit 3 while its counter is at 10
    @(negedge clk);
    bif.buttons_raw[3] = 1'b1;
    wait_cycles(D + 8);
    check("midrst_pressed_first", int'(bif.buttons[3]), 1);
    bif.buttons_raw[3] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_still_high", int'(bif.buttons[3]), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_buttons_cleared", int'(bif.buttons[3]), 0);
    check("midrst_no_released", int'(bif.released[3]), 0);
    check("midrst_sys_reset", int'(bif.sys_reset), 1);
    wait_cycles(2);
    reset_n = 1'b1;
    rc = 0;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (bif.released[3]) rc++;
      if (bif.buttons[3]) bad++;
    end
    check("midrst_no_released_after", rc, 0);
    check("midrst_stays_low", bad, 0);

    // Randomized phase: independent per-bit hold times, short and long
    for (int b = 0; b < N; b++) hold[b] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      if (cyc == 1200) reset_n = 1'b0;
      if (cyc == 1203) reset_n = 1'b1;
      for (int b = 0; b < N; b++) begin
        if (hold[b] == 0) begin
          bif.buttons_raw[b] = ~bif.buttons_raw[b];
          if ($urandom_range(0, 1) == 0) hold[b] = $urandom_range(1, 8);
          else                           hold[b] = $urandom_range(D - 2, 45);
        end else begin
          hold[b] = hold[b] - 1;
        end
      end
    end
    @(negedge clk);
    bif.buttons_raw = '0;
    wait_cycles(40);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
